// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin burst arbiters: default sizes,
// the lock state enum and a reference round-robin pick function.
package arb_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 32;
  localparam int PICK_MAX = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Returns {found, idx}: first set bit of valid scanning ptr, ptr+1, ... with
  // wrap-around. Callers with fewer than PICK_MAX lanes zero-extend valid.
  function automatic logic [3:0] rr_pick(input logic [PICK_MAX-1:0] valid,
                                         input logic [2:0] ptr);
    logic       found;
    logic [2:0] idx;
    found = |valid;
    idx   = '0;
    for (int i = PICK_MAX - 1; i >= 0; i--) begin
      if (valid[i]) idx = i[2:0];
    end
    for (int i = PICK_MAX - 1; i >= 0; i--) begin
      if (valid[i] && (i >= int'(ptr))) idx = i[2:0];
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: lowest valid lane at or after ptr,
// otherwise lowest valid lane overall (the wrap-around half).
module rr_priority_pick #(
  parameter  int N    = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [N-1:0] upper;

  // Lanes at or after ptr come first in rotated order.
  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = valid[i] && (i >= int'(ptr));
    end
  end

  // The upper-half scan runs last so it overrides the wrap-around result.
  always_comb begin
    found = |valid;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i]) idx = i[IDXW-1:0];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper[i]) idx = i[IDXW-1:0];
    end
  end

endmodule

// File: rtl/tl_rr_burst_arbiter.sv
// N-to-1 pass-through channel arbiter: round-robin between requesters, with
// the grant locked from the first presented beat until its last beat is taken.
module tl_rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int W    = W_DEF,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_bits,
  input  logic [N-1:0]    in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_bits,
  output logic            out_last,
  output logic [N-1:0]    out_sel,
  output arb_state_t      dbg_state,
  output logic [IDXW-1:0] dbg_rr_ptr
);

  // Handshake: a beat transfers on a cycle where valid and ready are both high;
  // a requester holds valid (and its bits) until that cycle, and ready never
  // depends on anything but the downstream ready and the current grant.

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic            grant_found;
  logic [IDXW-1:0] grant;
  logic            fire;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(N - 1)) ? '0 : i + IDXW'(1);
  endfunction

  rr_priority_pick #(.N(N)) u_pick (
    .valid (in_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // A presented beat locks the grant whether or not it fires, so a stall
  // cannot let another requester steal the channel.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (fire && out_last) begin
          rr_ptr_d = next_idx(grant);
        end else if (out_valid) begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant;
        end
      end
      ST_LOCKED: begin
        if (fire && out_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_idx(lock_idx_q);
        end
      end
    endcase
  end

  // Outputs are gated by reset so they drop the instant reset rises.
  always_comb begin
    grant_found = !reset && ((state_q == ST_LOCKED) || pick_found);
    grant       = (state_q == ST_LOCKED) ? lock_idx_q : pick_idx;
    out_sel     = '0;
    in_ready    = '0;
    out_valid   = 1'b0;
    out_bits    = '0;
    out_last    = 1'b0;
    if (grant_found) begin
      out_sel[grant]  = 1'b1;
      in_ready[grant] = out_ready;
      out_valid       = in_valid[grant];
      out_bits        = in_bits[int'(grant)*W +: W];
      out_last        = in_last[grant];
    end
    fire = out_valid && out_ready;
  end

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_tl_rr_burst_arbiter.sv
// Bench for tl_rr_burst_arbiter: directed scenarios on a 4x32 instance,
// a randomized run against a queue-based model, and a 2x8 payload check.
module tb_tl_rr_burst_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int N2 = 2;
  localparam int W2 = 8;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]   in_valid, in_ready, in_last, out_sel;
  logic [N*W-1:0] in_bits;
  logic           out_valid, out_ready, out_last;
  logic [W-1:0]   out_bits;
  arb_state_t     dbg_state;
  logic [1:0]     dbg_rr_ptr;

  logic [N2-1:0]    b_valid, b_ready, b_last, b_sel;
  logic [N2*W2-1:0] b_bits;
  logic             b_out_valid, b_out_ready, b_out_last;
  logic [W2-1:0]    b_out_bits;
  arb_state_t       b_dbg_state;
  logic [0:0]       b_dbg_rr_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  tl_rr_burst_arbiter #(.N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_bits(out_bits), .out_last(out_last),
    .out_sel(out_sel), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  tl_rr_burst_arbiter #(.N(N2), .W(W2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_bits(b_bits), .in_last(b_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_bits(b_out_bits), .out_last(b_out_last),
    .out_sel(b_sel), .dbg_state(b_dbg_state), .dbg_rr_ptr(b_dbg_rr_ptr)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int i);
    in_bits[i*W +: W] = $urandom;
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return in_bits[i*W +: W];
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    in_valid = '1; in_last = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_lane(i);
    b_valid = '0; b_last = '1; b_out_ready = 1'b1; b_bits = '0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, out_valid, out_sel} !== '0)
      $display("FAIL reset_outputs got ready=%b valid=%b sel=%b want 0", in_ready, out_valid, out_sel);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE || dbg_rr_ptr !== 2'd0)
      $display("FAIL reset_state got state=%0d ptr=%0d want 0/0", dbg_state, dbg_rr_ptr);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    in_valid = '0;
    tick();
  endtask

  task automatic test_rr_rotation();
    in_valid = '1; in_last = '1; out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      n_checks++;
      if (out_sel !== onehot(k) || out_bits !== lane(k))
        $display("FAIL rr_rotation k=%0d got sel=%b bits=%h want sel=%b bits=%h", k, out_sel, out_bits, onehot(k), lane(k));
      else n_pass++;
      tick();
      set_lane(k);
    end
    in_valid = '0;
    @(negedge clock);
    n_checks++;
    if (dbg_rr_ptr !== 2'd0) $display("FAIL rr_wrap got ptr=%0d want 0", dbg_rr_ptr);
    else n_pass++;
    tick();
  endtask

  task automatic test_burst_lock();
    in_valid = 4'b0001; in_last = '1; out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (out_sel !== 4'b0001) $display("FAIL burst_pre got sel=%b want 0001", out_sel);
    else n_pass++;
    tick();
    in_valid = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      in_last[2] = (b == 2);
      set_lane(2);
      @(negedge clock);
      n_checks++;
      if (out_sel !== 4'b0100 || in_ready !== 4'b0100 || out_bits !== lane(2) || out_last !== (b == 2))
        $display("FAIL burst_beat b=%0d got sel=%b rdy=%b bits=%h last=%b want 0100/0100/%h/%b",
                 b, out_sel, in_ready, out_bits, out_last, lane(2), (b == 2));
      else n_pass++;
      tick();
    end
    in_valid = 4'b0001;
    @(negedge clock);
    n_checks++;
    if (out_sel !== 4'b0001 || dbg_rr_ptr !== 2'd3)
      $display("FAIL burst_after got sel=%b ptr=%0d want 0001/3", out_sel, dbg_rr_ptr);
    else n_pass++;
    tick();
    in_valid = '0;
  endtask

  task automatic test_stall();
    in_valid = 4'b0010; in_last = '1; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) in_valid[0] = 1'b1;
      @(negedge clock);
      n_checks++;
      if (out_sel !== 4'b0010 || in_ready !== 4'b0000 || out_valid !== 1'b1)
        $display("FAIL stall c=%0d got sel=%b rdy=%b valid=%b want 0010/0000/1", c, out_sel, in_ready, out_valid);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0010) $display("FAIL stall_release got rdy=%b want 0010", in_ready);
    else n_pass++;
    tick();
    in_valid = 4'b0001;
    @(negedge clock);
    n_checks++;
    if (dbg_rr_ptr !== 2'd2 || out_sel !== 4'b0001)
      $display("FAIL stall_after got ptr=%0d sel=%b want 2/0001", dbg_rr_ptr, out_sel);
    else n_pass++;
    tick();
    in_valid = '0;
  endtask

  task automatic test_valid_gap();
    in_valid = 4'b1010; in_last = 4'b1000; out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (out_sel !== 4'b0010) $display("FAIL gap_start got sel=%b want 0010", out_sel);
    else n_pass++;
    tick();
    in_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_checks++;
      if (out_valid !== 1'b0 || out_sel !== 4'b0010 || dbg_state !== ST_LOCKED)
        $display("FAIL gap_hold c=%0d got valid=%b sel=%b state=%0d want 0/0010/1", c, out_valid, out_sel, dbg_state);
      else n_pass++;
      tick();
    end
    in_valid = 4'b1010; in_last = 4'b1010;
    @(negedge clock);
    n_checks++;
    if (out_sel !== 4'b0010 || out_last !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL gap_resume got sel=%b last=%b valid=%b want 0010/1/1", out_sel, out_last, out_valid);
    else n_pass++;
    tick();
    in_valid = 4'b1000;
    @(negedge clock);
    n_checks++;
    if (dbg_rr_ptr !== 2'd2 || out_sel !== 4'b1000)
      $display("FAIL gap_after got ptr=%0d sel=%b want 2/1000", dbg_rr_ptr, out_sel);
    else n_pass++;
    tick();
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    in_valid = 4'b1000; in_last = 4'b0000; out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (out_sel !== 4'b1000) $display("FAIL areset_pre got sel=%b want 1000", out_sel);
    else n_pass++;
    tick();
    in_valid = 4'b1001; in_last = 4'b0001;
    #2;
    n_checks++;
    if (out_sel !== 4'b1000 || dbg_state !== ST_LOCKED)
      $display("FAIL areset_locked got sel=%b state=%0d want 1000/1", out_sel, dbg_state);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_sel !== 4'b0000 || dbg_state !== ST_IDLE)
      $display("FAIL areset_drop got valid=%b rdy=%b sel=%b state=%0d want 0/0000/0000/0",
               out_valid, in_ready, out_sel, dbg_state);
    else n_pass++;
    @(posedge clock);
    #4 reset = 1'b0;
    #1;
    n_checks++;
    if (out_sel !== 4'b0001 || out_valid !== 1'b1)
      $display("FAIL areset_after got sel=%b valid=%b want 0001/1", out_sel, out_valid);
    else n_pass++;
    tick();
    in_valid = '0;
  endtask

  // Reference model: the channel belongs to an owner from its first presented
  // beat until its last beat is taken; otherwise the first valid requester
  // counting up from the pointer (mod N) wins.
  task automatic test_random();
    int           m_ptr, m_owner, g;
    bit           m_lock, has, e_valid, e_last;
    logic [N-1:0] e_sel, e_ready, accepted;
    logic [W-1:0] e_bits, got;
    reset = 1'b1; in_valid = '0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    m_ptr = 0; m_owner = 0; m_lock = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          in_last[i]  = ($urandom_range(0, 2) == 0);
          set_lane(i);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      has = 1'b0; g = 0;
      if (m_lock) begin
        has = 1'b1; g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!has && in_valid[(m_ptr + k) % N]) begin
            has = 1'b1; g = (m_ptr + k) % N;
          end
        end
      end
      e_sel = '0; e_ready = '0; e_valid = 1'b0; e_bits = '0; e_last = 1'b0;
      if (has) begin
        e_sel[g] = 1'b1; e_ready[g] = out_ready; e_valid = in_valid[g];
        e_bits = lane(g); e_last = in_last[g];
      end
      n_checks++;
      if ({out_sel, in_ready, out_valid, out_last} !== {e_sel, e_ready, e_valid, e_last} || out_bits !== e_bits)
        $display("FAIL rand_ctl cyc=%0d got sel=%b rdy=%b v=%b l=%b bits=%h want %b/%b/%b/%b/%h",
                 cyc, out_sel, in_ready, out_valid, out_last, out_bits, e_sel, e_ready, e_valid, e_last, e_bits);
      else n_pass++;
      n_checks++;
      if (dbg_rr_ptr !== 2'(m_ptr)) $display("FAIL rand_ptr cyc=%0d got %0d want %0d", cyc, dbg_rr_ptr, m_ptr);
      else n_pass++;
      // Scoreboard: the model queues each beat it expects to leave.
      if (e_valid && out_ready) exp_q.push_back(e_bits);
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_data cyc=%0d got unexpected beat %h want none", cyc, out_bits);
        else begin
          got = exp_q.pop_front();
          if (out_bits !== got) $display("FAIL rand_data cyc=%0d got %h want %h", cyc, out_bits, got);
          else n_pass++;
        end
      end
      if (e_valid && out_ready && e_last) begin
        m_lock = 1'b0; m_ptr = (g + 1) % N;
      end else if (e_valid) begin
        m_lock = 1'b1; m_owner = g;
      end
      accepted = in_valid & e_ready;
      tick();
      in_valid = in_valid & ~accepted;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rand_drain got %0d beats left want 0", exp_q.size());
    else n_pass++;
    in_valid = '0;
  endtask

  task automatic test_n2_payload();
    logic [N2-1:0] e_sel;
    int g;
    b_valid = 2'b11; b_last = 2'b11; b_out_ready = 1'b1;
    b_bits = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      g = k % 2;
      e_sel = '0; e_sel[g] = 1'b1;
      @(negedge clock);
      n_checks++;
      if (b_sel !== e_sel || b_out_bits !== b_bits[g*W2 +: W2] || b_ready !== e_sel)
        $display("FAIL n2_payload k=%0d got sel=%b bits=%h rdy=%b want %b/%h/%b",
                 k, b_sel, b_out_bits, b_ready, e_sel, b_bits[g*W2 +: W2], e_sel);
      else n_pass++;
      tick();
      b_bits[g*W2 +: W2] = 8'($urandom);
    end
    b_valid = '0;
    @(negedge clock);
    n_checks++;
    if (b_dbg_rr_ptr !== 1'b0) $display("FAIL n2_ptr got %0d want 0", b_dbg_rr_ptr);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_burst_lock();
    test_stall();
    test_valid_gap();
    test_async_reset();
    test_random();
    test_n2_payload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
